// File: rtl/text_console.sv
// Character console: VRAM, cursor FSM with clear sequencing, glyph pixel
// extraction and a blinking inverted cursor cell for a VGA timing stage.
module text_console #(
  parameter int COLS         = 70,
  parameter int ROWS         = 30,
  parameter int BLINK_FRAMES = 32
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  input  logic [6:0]  x,
  input  logic [4:0]  y,
  input  logic [9:0]  h_addr,
  input  logic [9:0]  v_addr,
  input  logic        valid,
  input  logic        vsync,
  output logic [11:0] font_addr,
  input  logic [8:0]  font_bits,
  output logic        rom_data,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y
);

  localparam int          CELLS     = COLS * ROWS;
  localparam logic [11:0] LAST_CELL = 12'(CELLS - 1);
  localparam logic [11:0] LAST_COL  = 12'(COLS - 1);

  typedef enum logic [1:0] {IDLE, CLR_ALL, CLR_ROW} state_t;

  state_t      r_state;
  logic [6:0]  r_cursorX;
  logic [4:0]  r_cursorY;
  logic        r_ready;
  logic [11:0] r_clrIdx;
  logic        r_vsyncPrev;
  logic [4:0]  r_frameCnt;
  logic        r_blinkOn;
  logic [7:0]  r_vram [0:CELLS-1];

  logic        w_xfer;
  logic        w_isPrint;
  logic        w_atLastCol;
  logic        w_advRow;
  logic [11:0] w_rowBase;
  logic [11:0] w_curIdx;
  logic        w_we;
  logic [11:0] w_waddr;
  logic [7:0]  w_wdata;
  logic [11:0] w_dispIdx;
  logic [7:0]  w_code;
  logic [10:0] w_off;
  logic        w_pix;
  logic        w_inv;

  assign w_xfer      = char_valid & r_ready;
  assign w_isPrint   = (char_data >= 8'h20) && (char_data <= 8'h7E);
  assign w_atLastCol = (r_cursorX == 7'(COLS - 1));
  assign w_advRow    = w_xfer & ((w_isPrint & w_atLastCol) | (char_data == 8'h0A));
  assign w_rowBase   = 12'(r_cursorY) * 12'(COLS);
  assign w_curIdx    = w_rowBase + 12'(r_cursorX);

  // Single VRAM write port shared by character writes, backspace erase and both clears.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = w_curIdx;
    w_wdata = 8'h20;
    if (!reset) begin
      case (r_state)
        IDLE: begin
          if (w_xfer && w_isPrint) begin
            w_we    = 1'b1;
            w_wdata = char_data;
          end else if (w_xfer && (char_data == 8'h08) && (r_cursorX != 7'd0)) begin
            w_we    = 1'b1;
            w_waddr = w_curIdx - 12'd1;
          end
        end
        CLR_ALL: begin
          w_we    = 1'b1;
          w_waddr = r_clrIdx;
        end
        CLR_ROW: begin
          w_we    = 1'b1;
          w_waddr = w_rowBase + r_clrIdx;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (w_we) r_vram[w_waddr] <= w_wdata;
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_state   <= CLR_ALL;
      r_clrIdx  <= 12'd0;
      r_ready   <= 1'b0;
      r_cursorX <= 7'd0;
      r_cursorY <= 5'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            if (w_isPrint) begin
              r_cursorX <= w_atLastCol ? 7'd0 : r_cursorX + 7'd1;
            end else begin
              case (char_data)
                8'h0A, 8'h0D: r_cursorX <= 7'd0;
                8'h08: if (r_cursorX != 7'd0) r_cursorX <= r_cursorX - 7'd1;
                8'h0C: begin
                  r_cursorX <= 7'd0;
                  r_cursorY <= 5'd0;
                  r_state   <= CLR_ALL;
                  r_clrIdx  <= 12'd0;
                  r_ready   <= 1'b0;
                end
                default: ;
              endcase
            end
            // Scrolling is by wrap: the new top row is blanked before more input.
            if (w_advRow) begin
              if (r_cursorY == 5'(ROWS - 1)) begin
                r_cursorY <= 5'd0;
                r_state   <= CLR_ROW;
                r_clrIdx  <= 12'd0;
                r_ready   <= 1'b0;
              end else begin
                r_cursorY <= r_cursorY + 5'd1;
              end
            end
          end
        end
        CLR_ALL: begin
          if (r_clrIdx == LAST_CELL) begin
            r_state  <= IDLE;
            r_ready  <= 1'b1;
            r_clrIdx <= 12'd0;
          end else begin
            r_clrIdx <= r_clrIdx + 12'd1;
          end
        end
        CLR_ROW: begin
          if (r_clrIdx == LAST_COL) begin
            r_state  <= IDLE;
            r_ready  <= 1'b1;
            r_clrIdx <= 12'd0;
          end else begin
            r_clrIdx <= r_clrIdx + 12'd1;
          end
        end
        default: begin
          r_state  <= CLR_ALL;
          r_clrIdx <= 12'd0;
          r_ready  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_vsyncPrev <= 1'b1;
      r_frameCnt  <= 5'd0;
      r_blinkOn   <= 1'b0;
    end else begin
      r_vsyncPrev <= vsync;
      if (r_vsyncPrev && !vsync) begin
        if (r_frameCnt == 5'(BLINK_FRAMES - 1)) begin
          r_frameCnt <= 5'd0;
          r_blinkOn  <= ~r_blinkOn;
        end else begin
          r_frameCnt <= r_frameCnt + 5'd1;
        end
      end
    end
  end

  // Off-screen coordinates read as a blank code rather than indexing past VRAM.
  assign w_dispIdx = 12'(y) * 12'(COLS) + 12'(x);
  assign w_code    = (w_dispIdx < 12'(CELLS)) ? r_vram[w_dispIdx] : 8'h00;
  assign font_addr = {w_code, v_addr[3:0]};
  assign w_off     = {1'b0, h_addr} - (11'(x) * 11'd9);
  assign w_pix     = (w_off <= 11'd8) ? font_bits[4'd8 - w_off[3:0]] : 1'b0;
  assign w_inv     = (x == r_cursorX) & (y == r_cursorY) & r_blinkOn;
  assign rom_data  = valid & (w_pix ^ w_inv);

  assign char_ready = r_ready;
  assign cursor_x   = r_cursorX;
  assign cursor_y   = r_cursorY;

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: clears, cursor motion, row wrap, backspace,
// display-path pixel selection and cursor blink.
module tb_text_console;

  localparam int COLS = 70;

  logic        pclk;
  logic        reset;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic [6:0]  x;
  logic [4:0]  y;
  logic [9:0]  h_addr;
  logic [9:0]  v_addr;
  logic        valid;
  logic        vsync;
  logic [11:0] font_addr;
  logic [8:0]  font_bits;
  logic        rom_data;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;

  int errors = 0;
  int checks = 0;

  text_console #(.COLS(70), .ROWS(30), .BLINK_FRAMES(32)) dut (
    .pclk(pclk), .reset(reset), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .x(x), .y(y), .h_addr(h_addr), .v_addr(v_addr),
    .valid(valid), .vsync(vsync), .font_addr(font_addr), .font_bits(font_bits),
    .rom_data(rom_data), .cursor_x(cursor_x), .cursor_y(cursor_y)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge pclk);
    #1;
  endtask

  // Waits (bounded) for char_ready, then presents one byte for exactly one edge.
  task automatic applyStimulus(input logic [7:0] c);
    int n;
    stepCycle();
    n = 0;
    while (char_ready !== 1'b1 && n < 5000) begin
      stepCycle();
      n++;
    end
    if (char_ready !== 1'b1) checkOutput("readyTimeout", {31'd0, char_ready}, 32'd1);
    char_valid = 1'b1;
    char_data  = c;
    stepCycle();
    char_valid = 1'b0;
  endtask

  task automatic countReadyLow(output int n);
    n = 0;
    while (char_ready !== 1'b1 && n < 5000) begin
      stepCycle();
      n++;
    end
  endtask

  task automatic readCell(input int idx, output logic [7:0] code);
    x      = 7'(idx % COLS);
    y      = 5'(idx / COLS);
    v_addr = 10'd0;
    #1;
    code = font_addr[11:4];
  endtask

  task automatic countBad(input int first, input int last, input logic [7:0] exp, output int bad);
    logic [7:0] code;
    bad = 0;
    for (int i = first; i <= last; i++) begin
      readCell(i, code);
      if (code !== exp) bad++;
    end
  endtask

  task automatic vsyncFall();
    stepCycle();
    vsync = 1'b0;
    stepCycle();
    vsync = 1'b1;
  endtask

  initial begin
    int n;
    int bad;
    logic [7:0] code;

    char_valid = 1'b0;
    char_data  = 8'h00;
    x = 7'd0; y = 5'd0; h_addr = 10'd0; v_addr = 10'd0;
    valid = 1'b0; vsync = 1'b1; font_bits = 9'd0;

    // One-cycle reset with a character offered during it.
    reset = 1'b1;
    char_valid = 1'b1;
    char_data  = 8'h41;
    stepCycle();
    reset = 1'b0;
    char_valid = 1'b0;
    checkOutput("resetReady", {31'd0, char_ready}, 32'd0);
    checkOutput("resetCurX", {25'd0, cursor_x}, 32'd0);
    checkOutput("resetCurY", {27'd0, cursor_y}, 32'd0);
    countReadyLow(n);
    checkOutput("clrAllLowCycles", n, 32'd2100);
    checkOutput("noAcceptInReset", {25'd0, cursor_x}, 32'd0);
    countBad(0, 2099, 8'h20, bad);
    checkOutput("allCellsBlank", bad, 32'd0);

    // 'A' then display-path probes.
    applyStimulus(8'h41);
    checkOutput("afterA_curX", {25'd0, cursor_x}, 32'd1);
    checkOutput("afterA_curY", {27'd0, cursor_y}, 32'd0);
    checkOutput("afterA_ready", {31'd0, char_ready}, 32'd1);
    x = 7'd0; y = 5'd0; v_addr = 10'd3; #1;
    checkOutput("fontAddrA", {20'd0, font_addr}, 32'h413);
    h_addr = 10'd0; font_bits = 9'h100; valid = 1'b1; #1;
    checkOutput("pixLeftmost", {31'd0, rom_data}, 32'd1);
    h_addr = 10'd5; font_bits = 9'h008; #1;
    checkOutput("pixOff5", {31'd0, rom_data}, 32'd1);
    font_bits = 9'h1F7; #1;
    checkOutput("pixOff5Clear", {31'd0, rom_data}, 32'd0);
    h_addr = 10'd9; font_bits = 9'h1FF; #1;
    checkOutput("pixOff9", {31'd0, rom_data}, 32'd0);
    x = 7'd1; h_addr = 10'd9; font_bits = 9'h100; #1;
    checkOutput("pixCol1", {31'd0, rom_data}, 32'd1);
    valid = 1'b0; #1;
    checkOutput("pixInvalid", {31'd0, rom_data}, 32'd0);
    font_bits = 9'd0;

    // Form feed, then a full row of 'B' wrapping to the next row.
    applyStimulus(8'h0C);
    countReadyLow(n);
    checkOutput("ffLowCycles", n, 32'd2100);
    checkOutput("ffCurX", {25'd0, cursor_x}, 32'd0);
    for (int i = 0; i < 70; i++) applyStimulus(8'h42);
    checkOutput("row0FullCurX", {25'd0, cursor_x}, 32'd0);
    checkOutput("row0FullCurY", {27'd0, cursor_y}, 32'd1);
    countBad(0, 69, 8'h42, bad);
    checkOutput("row0AllB", bad, 32'd0);
    readCell(70, code);
    checkOutput("cell70Blank", {24'd0, code}, 32'h20);

    // Row 1 marker, move to (5,29), then line feed wraps with a row clear.
    applyStimulus(8'h5A);
    applyStimulus(8'h0D);
    checkOutput("crCurX", {25'd0, cursor_x}, 32'd0);
    checkOutput("crCurY", {27'd0, cursor_y}, 32'd1);
    applyStimulus(8'h07);
    checkOutput("ignoredCurX", {25'd0, cursor_x}, 32'd0);
    for (int i = 0; i < 28; i++) applyStimulus(8'h0A);
    for (int i = 0; i < 5; i++) applyStimulus(8'h51);
    checkOutput("at5_29X", {25'd0, cursor_x}, 32'd5);
    checkOutput("at5_29Y", {27'd0, cursor_y}, 32'd29);
    applyStimulus(8'h0A);
    checkOutput("wrapReadyLow", {31'd0, char_ready}, 32'd0);
    countReadyLow(n);
    checkOutput("clrRowLowCycles", n, 32'd70);
    checkOutput("wrapCurX", {25'd0, cursor_x}, 32'd0);
    checkOutput("wrapCurY", {27'd0, cursor_y}, 32'd0);
    countBad(0, 69, 8'h20, bad);
    checkOutput("row0Cleared", bad, 32'd0);
    readCell(70, code);
    checkOutput("row1Kept", {24'd0, code}, 32'h5A);
    readCell(2030, code);
    checkOutput("row29Kept", {24'd0, code}, 32'h51);

    // Backspace at (3,0) and at column 0.
    applyStimulus(8'h0C);
    applyStimulus(8'h41);
    applyStimulus(8'h42);
    applyStimulus(8'h43);
    applyStimulus(8'h08);
    checkOutput("bsCurX", {25'd0, cursor_x}, 32'd2);
    readCell(2, code);
    checkOutput("bsCell2", {24'd0, code}, 32'h20);
    readCell(1, code);
    checkOutput("bsCell1", {24'd0, code}, 32'h42);
    for (int i = 0; i < 4; i++) applyStimulus(8'h0A);
    applyStimulus(8'h08);
    checkOutput("bsCol0X", {25'd0, cursor_x}, 32'd0);
    checkOutput("bsCol0Y", {27'd0, cursor_y}, 32'd4);

    // Reset in the middle of a clear restarts the full clear.
    applyStimulus(8'h0C);
    repeat (10) stepCycle();
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    countReadyLow(n);
    checkOutput("midClrResetLow", n, 32'd2100);

    // Cursor blink at (0,0) after 32 vsync falling edges.
    x = 7'd0; y = 5'd0; h_addr = 10'd0; font_bits = 9'd0; valid = 1'b1;
    for (int i = 0; i < 31; i++) vsyncFall();
    stepCycle();
    checkOutput("blinkOff31", {31'd0, rom_data}, 32'd0);
    vsyncFall();
    stepCycle();
    checkOutput("blinkOn32", {31'd0, rom_data}, 32'd1);
    valid = 1'b0; #1;
    checkOutput("blinkInvalid", {31'd0, rom_data}, 32'd0);
    valid = 1'b1; x = 7'd1; h_addr = 10'd9; #1;
    checkOutput("blinkOtherCell", {31'd0, rom_data}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
